oam_dma_ctrl: RTL and testbench

//  Sits between the CPU-side master (sys_ctrl_fsm / CPU core) and mem_ctrl and owns the shared CPU address bus.
//  In IDLE it passes CPU bus cycles straight through to mem_ctrl.
//  A CPU write to the OAM DMA register starts a transfer: the CPU is halted, then XFER_LEN bytes are copied

---
 rtl/nes_bus_pkg.sv | 22 ++
 rtl/oam_dma_ctrl.sv | 136 +++++++++++++
 tb/tb_oam_dma_ctrl.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/nes_bus_pkg.sv
// -----------------------------------------------------------------------------
// nes_bus_pkg
//   Shared CPU-bus constants and the OAM DMA controller state encoding.
//   DMA_REG_ADDR  : CPU address whose write starts an OAM DMA (data = page)
//   OAM_DATA_ADDR : mem_ctrl address that writes sprite RAM and post-increments
//                   the sprite RAM pointer
// -----------------------------------------------------------------------------
package nes_bus_pkg;

  localparam logic [15:0] DMA_REG_ADDR  = 16'h4014;
  localparam logic [15:0] OAM_DATA_ADDR = 16'h2004;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    HALT_WAIT = 3'd1,
    RD_REQ    = 3'd2,
    RD_CAP    = 3'd3,
    WR_REQ    = 3'd4,
    DONE      = 3'd5
  } dma_state_e;

endpackage

// File: rtl/oam_dma_ctrl.sv
// -----------------------------------------------------------------------------
// oam_dma_ctrl
//   Owns the CPU address bus in front of mem_ctrl. In IDLE, CPU cycles pass
//   straight through. A CPU write to DMA_REG_ADDR halts the CPU and copies
//   XFER_LEN bytes from {page,8'h00} into sprite RAM through OAM_DATA_ADDR.
//
// Ports
//   clk, rst            : clock, asynchronous active-high reset
//   cpu_addr/wdata/we/re: CPU master bus in
//   cpu_rdata           : read data back to CPU (0 while DMA owns the bus)
//   cpu_halt            : halt request to CPU; cpu_is_halted is its ack
//   mem_addr/wdata/we/re: bus out to mem_ctrl
//   mem_rdata           : mem_ctrl read data, valid one cycle after mem_re
//   mem_busy            : mem_ctrl busy; strobes are only issued while low
//   dma_active          : high whenever not IDLE
//   dma_done            : one-cycle pulse at the end of a transfer
//
// State      | meaning
// IDLE       | pass-through; watching for DMA register write
// HALT_WAIT  | halt requested, waiting for CPU acknowledge
// RD_REQ     | issue source read {page,idx} when mem not busy
// RD_CAP     | capture read data
// WR_REQ     | issue sprite RAM write when mem not busy
// DONE       | one-cycle completion pulse
// -----------------------------------------------------------------------------
module oam_dma_ctrl
  import nes_bus_pkg::*;
#(
  parameter int XFER_LEN = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cpu_addr,
  input  logic [7:0]  cpu_wdata,
  input  logic        cpu_we,
  input  logic        cpu_re,
  output logic [7:0]  cpu_rdata,
  output logic        cpu_halt,
  input  logic        cpu_is_halted,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_we,
  output logic        mem_re,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_busy,
  output logic        dma_active,
  output logic        dma_done
);

  localparam logic [7:0] LAST_IDX = 8'(XFER_LEN - 1);

  dma_state_e state_q, state_d;
  logic [7:0] page_q, page_d;
  logic [7:0] idx_q, idx_d;
  logic [7:0] data_q, data_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      page_q  <= 8'h00;
      idx_q   <= 8'h00;
      data_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      page_q  <= page_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    page_d    = page_q;
    idx_d     = idx_q;
    data_d    = data_q;
    // Outside IDLE the bus rests on the source address so it stays stable
    // across stalls; CPU reads see zero.
    mem_addr  = {page_q, idx_q};
    mem_wdata = data_q;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    cpu_rdata = 8'h00;

    unique case (state_q)
      IDLE: begin
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        mem_we    = cpu_we;
        mem_re    = cpu_re;
        cpu_rdata = mem_rdata;
        // The DMA register lives here, so its write is swallowed.
        if (cpu_we && (cpu_addr == DMA_REG_ADDR)) begin
          mem_we  = 1'b0;
          page_d  = cpu_wdata;
          idx_d   = 8'h00;
          state_d = HALT_WAIT;
        end
      end
      HALT_WAIT: begin
        if (cpu_is_halted) state_d = RD_REQ;
      end
      RD_REQ: begin
        mem_re = !mem_busy;
        if (!mem_busy) state_d = RD_CAP;
      end
      RD_CAP: begin
        data_d  = mem_rdata;
        state_d = WR_REQ;
      end
      WR_REQ: begin
        mem_addr = OAM_DATA_ADDR;
        mem_we   = !mem_busy;
        if (!mem_busy) begin
          if (idx_q == LAST_IDX) begin
            state_d = DONE;
          end else begin
            idx_d   = idx_q + 8'd1;
            state_d = RD_REQ;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Decoded straight from the state register so halt never glitches.
  assign dma_active = (state_q != IDLE);
  assign cpu_halt   = dma_active;
  assign dma_done   = (state_q == DONE);

endmodule

// File: tb/tb_oam_dma_ctrl.sv
module tb_oam_dma_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] cpu_addr = 16'h0000;
  logic [7:0]  cpu_wdata = 8'h00;
  logic        cpu_we = 1'b0;
  logic        cpu_re = 1'b0;
  logic [7:0]  cpu_rdata;
  logic        cpu_halt;
  logic        cpu_is_halted = 1'b0;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_we;
  logic        mem_re;
  logic [7:0]  mem_rdata = 8'h00;
  logic        mem_busy = 1'b0;
  logic        dma_active;
  logic        dma_done;

  oam_dma_ctrl dut (
    .clk(clk), .rst(rst),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_we(cpu_we), .cpu_re(cpu_re),
    .cpu_rdata(cpu_rdata), .cpu_halt(cpu_halt), .cpu_is_halted(cpu_is_halted),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
    .mem_rdata(mem_rdata), .mem_busy(mem_busy),
    .dma_active(dma_active), .dma_done(dma_done)
  );

  always #5 clk = ~clk;

  // mem_ctrl model: registered read data, OAM data port with auto-increment.
  logic [7:0] mem   [0:65535];
  logic [7:0] spram [0:255];
  logic [7:0] oam_ptr;

  always @(posedge clk) begin
    if (mem_re) mem_rdata <= mem[mem_addr];
  end

  always @(posedge clk or posedge rst) begin
    if (rst) oam_ptr <= 8'h00;
    else if (mem_we && mem_addr == 16'h2004) begin
      spram[oam_ptr] <= mem_wdata;
      oam_ptr        <= oam_ptr + 8'd1;
    end
  end

  function automatic logic [7:0] src_byte(input logic [7:0] pg, input logic [7:0] i);
    if (pg == 8'h02) return i ^ 8'hA5;
    return i ^ 8'h3C ^ pg;
  endfunction

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
    end
  endtask

  // monitor state
  logic [7:0]  exp_pg;
  int rd_k, wr_k, halt_cnt, done_cnt, both_cnt, busy_str, fwd_cnt, early_cnt;
  int zero_cnt, addr_err, wr_err, stab_err;
  bit ack_seen, have_prev, prev_busy, prev_cand;
  logic [15:0] prev_addr;
  logic [7:0]  prev_wdata;

  task automatic mon_clear(input logic [7:0] pg);
    exp_pg = pg; rd_k = 0; wr_k = 0; halt_cnt = 0; done_cnt = 0; both_cnt = 0;
    busy_str = 0; fwd_cnt = 0; early_cnt = 0; zero_cnt = 0; addr_err = 0;
    wr_err = 0; stab_err = 0; ack_seen = 0; have_prev = 0;
  endtask

  task automatic mon_cycle();
    if (cpu_halt) halt_cnt++;
    if (dma_done) done_cnt++;
    if (mem_re && mem_we) both_cnt++;
    if ((mem_re || mem_we) && mem_busy) busy_str++;
    if (mem_we && mem_addr == 16'h4014) fwd_cnt++;
    if (cpu_halt && !ack_seen && (mem_re || mem_we)) early_cnt++;
    if (cpu_halt && cpu_is_halted) ack_seen = 1;
    if ((mem_re || mem_we) && mem_addr == 16'h0000) zero_cnt++;
    if (have_prev && prev_busy && prev_cand &&
        (mem_addr != prev_addr || mem_wdata != prev_wdata)) stab_err++;
    if (cpu_halt && mem_re) begin
      if (rd_k > 255 || mem_addr != {exp_pg, 8'(rd_k)}) addr_err++;
      rd_k++;
    end
    if (cpu_halt && mem_we) begin
      if (mem_addr != 16'h2004 || mem_wdata != src_byte(exp_pg, 8'(wr_k))) wr_err++;
      wr_k++;
    end
    have_prev  = 1;
    prev_busy  = mem_busy;
    prev_addr  = mem_addr;
    prev_wdata = mem_wdata;
    prev_cand  = cpu_halt && (mem_addr == 16'h2004 ||
                 (rd_k < 256 && mem_addr == {exp_pg, 8'(rd_k)}));
  endtask

  // Trigger a DMA and run it until dma_done (or reset injection / timeout).
  task automatic run_dma(input logic [7:0] pg, input int halt_dly, input bit busy_rnd,
                         input int inject_at, input int rst_at, output bit done);
    int  cyc;
    bit  inj;
    cyc = 0; inj = 0; done = 0;
    mon_clear(pg);
    @(posedge clk); #1;
    cpu_addr = 16'h4014; cpu_wdata = pg; cpu_we = 1'b1; cpu_re = 1'b0;
    cpu_is_halted = (halt_dly == 0); mem_busy = 1'b0;
    while (cyc < 5000 && !done) begin
      @(negedge clk);
      mon_cycle();
      if (dma_done) begin
        done = 1;
      end else begin
        @(posedge clk); #1;
        cyc++;
        cpu_we = 1'b0;
        cpu_is_halted = (cyc > halt_dly);
        mem_busy = busy_rnd ? 1'($urandom_range(0, 1)) : 1'b0;
        if (inject_at >= 0 && !inj && rd_k == inject_at) begin
          cpu_addr = 16'h4014; cpu_wdata = 8'h03; cpu_we = 1'b1; inj = 1;
        end
        if (rst_at >= 0 && rd_k == rst_at) begin
          rst = 1'b1;
          #1;
          check("rst_halt_same_cycle", {31'd0, cpu_halt}, 32'd0);
          check("rst_active_same_cycle", {31'd0, dma_active}, 32'd0);
          return;
        end
      end
    end
    check("dma_done_seen", {31'd0, done}, 32'd1);
    mem_busy = 1'b0;
    @(posedge clk); #1;
    check("idle_after_done", {31'd0, dma_active}, 32'd0);
  endtask

  task automatic check_spram(input string tag, input logic [7:0] pg);
    int e;
    e = 0;
    for (int i = 0; i < 256; i++)
      if (spram[i] !== src_byte(pg, 8'(i))) e++;
    check(tag, e, 0);
  endtask

  initial begin
    bit ok;
    for (int i = 0; i < 256; i++) begin
      mem[{8'h02, 8'(i)}] = src_byte(8'h02, 8'(i));
      mem[{8'hFF, 8'(i)}] = src_byte(8'hFF, 8'(i));
      mem[{8'h05, 8'(i)}] = src_byte(8'h05, 8'(i));
    end
    mem[16'h0300] = 8'h5A;
    mem[16'h0000] = 8'h00;

    // reset state
    cpu_addr = 16'h1234; cpu_wdata = 8'h77;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cpu_halt", {31'd0, cpu_halt}, 32'd0);
    check("rst_dma_active", {31'd0, dma_active}, 32'd0);
    check("rst_dma_done", {31'd0, dma_done}, 32'd0);
    check("rst_passthru_addr", {16'd0, mem_addr}, 32'h1234);
    @(posedge clk); #1;
    rst = 1'b0;

    // 1: pass-through
    cpu_addr = 16'h0300; cpu_re = 1'b1;
    @(negedge clk);
    check("pt_rd_strobe", {31'd0, mem_re}, 32'd1);
    check("pt_rd_addr", {16'd0, mem_addr}, 32'h0300);
    @(posedge clk); #1;
    cpu_re = 1'b0;
    @(negedge clk);
    check("pt_rdata", {24'd0, cpu_rdata}, 32'h5A);
    @(posedge clk); #1;
    cpu_addr = 16'h2003; cpu_wdata = 8'h10; cpu_we = 1'b1;
    @(negedge clk);
    check("pt_wr_strobe", {31'd0, mem_we}, 32'd1);
    check("pt_wr_addr", {16'd0, mem_addr}, 32'h2003);
    check("pt_wr_data", {24'd0, mem_wdata}, 32'h10);
    @(posedge clk); #1;
    cpu_we = 1'b0;

    // 2: basic DMA
    run_dma(8'h02, 0, 1'b0, -1, -1, ok);
    check("t2_halt_cycles", halt_cnt, 770);
    check("t2_done_pulses", done_cnt, 1);
    check("t2_reg_fwd", fwd_cnt, 0);
    check("t2_reads", rd_k, 256);
    check("t2_writes", wr_k, 256);
    check("t2_addr_err", addr_err, 0);
    check("t2_wdata_err", wr_err, 0);
    check("t2_re_we_both", both_cnt, 0);
    check_spram("t2_spram", 8'h02);

    // 3: halt handshake
    run_dma(8'h02, 10, 1'b0, -1, -1, ok);
    check("t3_early_strobe", early_cnt, 0);
    check("t3_halt_cycles", halt_cnt, 780);
    check("t3_done_pulses", done_cnt, 1);
    check_spram("t3_spram", 8'h02);

    // 4: backpressure
    run_dma(8'h05, 0, 1'b1, -1, -1, ok);
    check("t4_strobe_busy", busy_str, 0);
    check("t4_stall_stable", stab_err, 0);
    check("t4_re_we_both", both_cnt, 0);
    check("t4_reads", rd_k, 256);
    check("t4_wdata_err", wr_err, 0);
    check_spram("t4_spram", 8'h05);

    // 5: page FF, mid-DMA register write dropped
    run_dma(8'hFF, 0, 1'b0, 40, -1, ok);
    check("t5_addr_err", addr_err, 0);
    check("t5_zero_access", zero_cnt, 0);
    check("t5_reads", rd_k, 256);
    check("t5_reg_fwd", fwd_cnt, 0);
    check("t5_done_pulses", done_cnt, 1);
    check_spram("t5_spram", 8'hFF);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("t5_no_retrigger", {31'd0, dma_active}, 32'd0);

    // 6: reset mid-op
    run_dma(8'h02, 0, 1'b0, -1, 100, ok);
    check("t6_reads_before_rst", rd_k, 100);
    begin
      int strobes;
      strobes = 0;
      cpu_we = 1'b0; cpu_re = 1'b0; mem_busy = 1'b0;
      for (int i = 0; i < 6; i++) begin
        @(negedge clk);
        if (mem_re || mem_we || cpu_halt) strobes++;
        @(posedge clk); #1;
        if (i == 2) rst = 1'b0;
      end
      check("t6_quiet_after_rst", strobes, 0);
    end
    run_dma(8'h05, 0, 1'b0, -1, -1, ok);
    check("t6_halt_cycles", halt_cnt, 770);
    check("t6_reads", rd_k, 256);
    check_spram("t6_spram", 8'h05);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
